// File: rtl/tracker_pkg.sv
// rtl/tracker_pkg.sv - Shared FSM states, default parameters and stall indexing for the commit tracker
package tracker_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        RUN,
        DONE,
        TOUT
    } tracker_state_e;

    localparam int DEF_NUM_STAGES = 4;
    localparam int DEF_NUM_PIPES  = 2;
    localparam int DEF_MAX_CYCLES = 50;
    localparam int DEF_CNT_W      = 8;

    // Flat position of the stall bit for a given pipe and stage (stage 0 is S1).
    function automatic int stall_idx(input int pipe, input int stage, input int num_stages);
        return pipe * num_stages + stage;
    endfunction

endpackage

// File: rtl/stage_chain.sv
// rtl/stage_chain.sv - One pipe's stall-gated token shift chain with registered commit
module stage_chain #(
    parameter int NUM_STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s1_gate,
    input  logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] token,
    output logic                  commit
);

    logic [NUM_STAGES-1:1] tok_q;
    logic [NUM_STAGES-1:1] tok_d;
    logic [NUM_STAGES-1:0] nxt;
    logic                  commit_q;
    logic                  commit_d;

    // Stage 0 exists only during the launch cycle; later stages are registered.
    assign token  = {tok_q, start & s1_gate & ~stall[0]};
    assign nxt    = token & ~stall;
    assign commit = commit_q;

    // A stalled stage keeps its contents; an unstalled one takes whatever leaves the stage before it.
    always_comb begin
        tok_d = tok_q;
        for (int k = 1; k < NUM_STAGES; k++) begin
            if (!stall[k]) begin
                tok_d[k] = nxt[k-1];
            end
        end
        commit_d = nxt[NUM_STAGES-1];
    end

    // Token and commit registers, cleared on reset so an aborted check leaves nothing in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            tok_q    <= '0;
            commit_q <= 1'b0;
        end else begin
            tok_q    <= tok_d;
            commit_q <= commit_d;
        end
    end

endmodule

// File: rtl/refine_commit_tracker.sv
// rtl/refine_commit_tracker.sv - Launch/track/commit monitor for refinement checks; TRACKER_REISSUE_EN enables relaunch after DONE/TOUT
module refine_commit_tracker
    import tracker_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int NUM_PIPES  = DEF_NUM_PIPES,
    parameter int MAX_CYCLES = DEF_MAX_CYCLES,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            issue,
    input  logic [NUM_PIPES-1:0]            s1_gate,
    input  logic [NUM_PIPES*NUM_STAGES-1:0] stall,
    input  logic [NUM_PIPES-1:0]            commit_sel,
    output logic                            start,
    output logic                            started,
    output logic [CNT_W-1:0]                cycle_cnt,
    output logic [NUM_PIPES*NUM_STAGES-1:0] token,
    output logic [NUM_PIPES-1:0]            commit,
    output logic                            iend,
    output logic                            ended,
    output logic                            end2,
    output logic                            timeout
);

    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MAX_CYCLES + 1);

    tracker_state_e   state_q, state_d;
    logic             started_q, started_d;
    logic             ended_q, ended_d;
    logic             end2_q, end2_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit;

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
        stage_chain #(
            .NUM_STAGES(NUM_STAGES)
        ) u_chain (
            .clk    (clk),
            .rst    (rst),
            .start  (start),
            .s1_gate(s1_gate[g]),
            .stall  (stall[stall_idx(g, 0, NUM_STAGES) +: NUM_STAGES]),
            .token  (token[g*NUM_STAGES +: NUM_STAGES]),
            .commit (commit[g])
        );
    end

    // Sticky end flags become visible in the same cycle as the commit that sets them.
    assign started   = started_q;
    assign cycle_cnt = cnt_q;
    assign ended     = ended_q | iend;
    assign end2      = end2_q | (hit & ended_q);
    assign timeout   = timeout_q;

    // Next-state, counter and termination logic.
    always_comb begin
        state_d   = state_q;
        started_d = started_q;
        ended_d   = ended_q;
        end2_d    = end2_q;
        timeout_d = timeout_q;
        cnt_d     = cnt_q;
        start     = (state_q == LAUNCH);
        hit       = |(commit & commit_sel);
        iend      = hit & started_q & ~ended_q & (cnt_q <= MAX_C);

        if ((start || started_q) && (cnt_q < CNT_LIM)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (iend) begin
            ended_d = 1'b1;
        end
        if (hit && ended_q) begin
            end2_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                state_d   = RUN;
                started_d = 1'b1;
            end
            RUN: begin
                // An in-bound commit always wins over the bound check.
                if (iend) begin
                    state_d = DONE;
                end else if ((cnt_q > MAX_C) && !ended_q) begin
                    state_d   = TOUT;
                    timeout_d = 1'b1;
                end
            end
            DONE, TOUT: begin
`ifdef TRACKER_REISSUE_EN
                // Wait for every stray token to drain before rearming.
                if (~|token) begin
                    state_d   = IDLE;
                    started_d = 1'b0;
                    ended_d   = 1'b0;
                    end2_d    = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = '0;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            ended_q   <= 1'b0;
            end2_q    <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            started_q <= started_d;
            ended_q   <= ended_d;
            end2_q    <= end2_d;
            timeout_q <= timeout_d;
            cnt_q     <= cnt_d;
        end
    end

endmodule

// File: doc/refine_commit_tracker.md
Name: refine_commit_tracker

Overview:
- Parametrised instruction-tracking monitor for refinement checks of the L2 pipelines against the ILA model.
- Launches one token per check, follows it through N stall-gated stages on each of P pipes, and detects commit.
- Generates the start/started/ended/second-ended control and the cycle bound used by the property harness.
- Generalises the fixed 4-stage/3-stage, two-pipe hand-written monitors. Adds timeout detection and per-pipe commit selection.

Parameters:
- NUM_STAGES, 4, stages per pipe including the commit register source; legal range 2..8.
- NUM_PIPES, 2, number of tracked pipes; legal range 1..4.
- MAX_CYCLES, 50, last cycle_cnt value at which a commit counts as in-bound.
- CNT_W, 8, cycle counter width; must hold MAX_CYCLES+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- issue  in  1  request to launch a tracked instruction.
- s1_gate  in  NUM_PIPES  per-pipe S1 qualifier (e.g. valid_S1); tie high for ungated pipes.
- stall  in  NUM_PIPES*NUM_STAGES  stall for pipe p, stage k at bit p*NUM_STAGES+k; k=0 is S1.
- commit_sel  in  NUM_PIPES  pipes whose commit terminates the check.
- start  out  1  one-cycle launch pulse.
- started  out  1  sticky; set the cycle after start.
- cycle_cnt  out  CNT_W  cycles since launch.
- token  out  NUM_PIPES*NUM_STAGES  token present at stage k of pipe p.
- commit  out  NUM_PIPES  registered commit per pipe.
- iend  out  1  in-bound first-end pulse.
- ended  out  1  sticky first end.
- end2  out  1  sticky second end.
- timeout  out  1  sticky bound violation.

Behaviour:
- Reset: every output and every internal register is 0; FSM = IDLE. A reset asserted mid-check aborts the check and clears all tokens the same cycle it is sampled.
- FSM states: IDLE, LAUNCH, RUN, DONE, TOUT.
  - IDLE -> LAUNCH when issue is high. start is high exactly while in LAUNCH.
  - LAUNCH -> RUN unconditionally; started is set on this edge.
  - RUN -> DONE on iend.
  - RUN -> TOUT when cycle_cnt > MAX_CYCLES with ended low; timeout is set.
  - DONE and TOUT are held until reset (see Optional Feature).
- cycle_cnt: increments when (start|started) and cycle_cnt < MAX_CYCLES+1; it saturates at MAX_CYCLES+1.
- Stage 0 token (combinational): start & s1_gate[p] & ~stall[p][0].
- Stage k>=1 token: registered. It loads next[k-1] when ~stall[p][k] and holds otherwise.
- next[k] = token[k] & ~stall[p][k].
- commit[p] is registered next[NUM_STAGES-1], so it is high for one cycle. Latency with no stalls = NUM_STAGES cycles after start.
- Only one token per pipe is in flight at a time; a stage register is never overwritten while it holds a token.
- Termination:
  - hit = |(commit & commit_sel).
  - iend = hit & started & ~ended & (cycle_cnt <= MAX_CYCLES).
  - ended is set on iend.
  - end2 is set on the first hit in a cycle after ended is set.
- Boundary cases:
  - A hit when cycle_cnt == MAX_CYCLES is in-bound.
  - A hit and the timeout condition in the same cycle resolve as iend; timeout stays 0.
  - A hit on a pipe with commit_sel=0 only pulses commit.
  - issue while not in IDLE is ignored.

Optional Feature:
- Macro: TRACKER_REISSUE_EN.
- When defined: DONE or TOUT -> IDLE once all token bits are 0. This transition clears started, ended, end2, timeout and cycle_cnt, so a new issue launches another check without reset.
- When undefined: DONE and TOUT are terminal until rst, and issue is ignored after the first launch.

Decomposition:
- Package tracker_pkg holds the FSM state enum (IDLE, LAUNCH, RUN, DONE, TOUT), the default parameter constants and a function computing the stall bit index.
- Sub-module stage_chain implements one pipe's stall-gated token shift chain and commit register. It is instantiated NUM_PIPES times.

Test Plan:
- NUM_STAGES=4, P=2, no stalls, s1_gate=2'b11, commit_sel=2'b01, issue=1 at cycle 0 -> start at cycle 1; commit[0] at cycle 5; iend and ended at cycle 5 with cycle_cnt=4.
- Pipe 0 stall[2] held for 3 cycles while its token is at stage 2 -> commit[0] is delayed exactly 3 cycles; token[0][2] is held throughout.
- s1_gate[1]=0 during start -> token on pipe 1 never appears and commit[1] stays 0; pipe 0 commits normally.
- MAX_CYCLES=10, stall[3] held 20 cycles -> timeout=1 and FSM=TOUT at cycle_cnt=11; the later commit gives no iend.
- commit_sel=2'b11, pipe 1 commits 2 cycles after pipe 0 -> iend on pipe 0's commit; end2 set 2 cycles later.
- rst asserted mid-RUN -> all outputs 0 next cycle. With TRACKER_REISSUE_EN, a second issue after DONE reruns the check with cycle_cnt restarting at 0.
